// File: rtl/adder_pkg.sv
// Shared definitions for the adder pipeline: operation encodings.
package adder_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    ACC  = 2'b10,
    LOAD = 2'b11
  } adder_mode_t;

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice; accepts a new beat whenever empty or draining.
module pipe_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          load;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Two-stage add/sub/accumulate pipeline with valid/ready handshakes.
// Define ADDER_PIPE_SAT_EN to saturate the result instead of wrapping.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned S1_W = 2 * WIDTH + MODE_W;
  localparam int unsigned S2_W = WIDTH + 2;

  logic [S1_W-1:0]  s1_in, s1_out;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  adder_mode_t      s1_mode;

  logic [S2_W-1:0]  s2_in, s2_out;
  logic             s2_in_ready;
  logic             s2_load;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_x, op_y;
  logic             cin;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry, res_ovf;

  assign s1_in = {a, b, mode};

  pipe_stage #(.DW(S1_W)) u_s1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (s1_in),
    .in_ready_o  (in_ready),
    .out_valid_o (s1_valid),
    .out_data_o  (s1_out),
    .out_ready_i (s2_in_ready)
  );

  assign s1_a    = s1_out[S1_W-1 -: WIDTH];
  assign s1_b    = s1_out[MODE_W +: WIDTH];
  assign s1_mode = adder_mode_t'(s1_out[MODE_W-1:0]);
  assign s2_load = s1_valid && s2_in_ready;

  always_comb begin
    op_x = s1_a;
    op_y = s1_b;
    cin  = 1'b0;
    unique case (s1_mode)
      ADD:  ;
      SUB:  begin op_y = ~s1_b; cin = 1'b1; end
      ACC:  begin op_x = acc_q; op_y = s1_a; end
      LOAD: op_y = '0;
    endcase
    raw       = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
    res_sum   = raw[WIDTH-1:0];
    res_carry = raw[WIDTH];
    res_ovf   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (raw[WIDTH-1] != op_x[WIDTH-1]);
    if (s1_mode == LOAD) begin
      res_carry = 1'b0;
      res_ovf   = 1'b0;
    end
`ifdef ADDER_PIPE_SAT_EN
    // Clamp only the sum; carry/overflow keep reporting the raw condition.
    if ((s1_mode == ADD || s1_mode == ACC) && res_carry) res_sum = '1;
    if (s1_mode == SUB && !res_carry) res_sum = '0;
`endif
  end

  always_comb begin
    acc_d = acc_q;
    if (s2_load && (s1_mode == ACC || s1_mode == LOAD)) acc_d = res_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign s2_in = {res_sum, res_carry, res_ovf};

  pipe_stage #(.DW(S2_W)) u_s2 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (s1_valid),
    .in_data_i   (s2_in),
    .in_ready_o  (s2_in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (s2_out),
    .out_ready_i (out_ready)
  );

  assign sum      = s2_out[S2_W-1 -: WIDTH];
  assign carry    = s2_out[1];
  assign overflow = s2_out[0];

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe at WIDTH=4.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int unsigned W = 4;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [W-1:0] EXP_ADD_WRAP = 4'd15;
  localparam logic [W-1:0] EXP_SUB_BORR = 4'd0;
  localparam logic [W-1:0] EXP_ACC_LAST = 4'd15;
`else
  localparam logic [W-1:0] EXP_ADD_WRAP = 4'd0;
  localparam logic [W-1:0] EXP_SUB_BORR = 4'd15;
  localparam logic [W-1:0] EXP_ACC_LAST = 4'd1;
`endif

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic [1:0]   mode;
  logic         carry, overflow;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] res_q[$];

  adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a negedge sample sees the coming handshake.
  always @(negedge clk)
    if (!rst && out_valid && out_ready) res_q.push_back({sum, carry, overflow});

  task automatic push_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [1:0] tm, output int waited);
    in_valid = 1'b1; a = ta; b = tb; mode = tm; waited = 0;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      waited++;
    end
    checks++; errors++;
    $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 50 && res_q.size() < n; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (res_q.size() < n) begin
      errors++;
      $display("FAIL result_timeout: got %0d results, required %0d", res_q.size(), n);
      while (res_q.size() < n) res_q.push_back('x);
    end
  endtask

  task automatic check_res(input string nm, input int idx, input logic [W-1:0] es,
                           input logic ec, input logic eo);
    logic [W+1:0] r;
    r = res_q[idx];
    checks++;
    if (r !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s: sum=%0d carry=%b ovf=%b, required sum=%0d carry=%b ovf=%b",
               nm, r[W+1:2], r[1], r[0], es, ec, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, sum, carry, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sum=%0d c=%b o=%b, required all 0",
               out_valid, sum, carry, overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    res_q.delete();
    in_valid = 1'b1; a = 4'd1; b = 4'd0; mode = ADD; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c1: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== 4'd1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL latency_c2: valid=%b sum=%0d carry=%b, required 1 1 0", out_valid, sum, carry);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_c3: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_add_sub();
    int w;
    res_q.delete();
    push_beat(4'd15, 4'd1, ADD, w);
    push_beat(4'd7,  4'd1, ADD, w);
    push_beat(4'd2,  4'd3, SUB, w);
    in_valid = 1'b0;
    wait_results(3);
    check_res("add_15_1", 0, EXP_ADD_WRAP, 1'b1, 1'b0);
    check_res("add_7_1",  1, 4'd8,         1'b0, 1'b1);
    check_res("sub_2_3",  2, EXP_SUB_BORR, 1'b0, 1'b0);
  endtask

  task automatic test_acc();
    int w0, w1, w2;
    res_q.delete();
    push_beat(4'd3, 4'd0, LOAD, w0);
    push_beat(4'd5, 4'd0, ACC,  w1);
    push_beat(4'd9, 4'd0, ACC,  w2);
    in_valid = 1'b0;
    checks++;
    if (w0 + w1 + w2 != 0) begin
      errors++;
      $display("FAIL acc_stall: stalled %0d cycles, required 0", w0 + w1 + w2);
    end
    wait_results(3);
    check_res("load_3", 0, 4'd3,         1'b0, 1'b0);
    check_res("acc_5",  1, 4'd8,         1'b0, 1'b1);
    check_res("acc_9",  2, EXP_ACC_LAST, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int w, total;
    res_q.delete();
    total = 0;
    for (int i = 0; i < 4; i++) begin
      push_beat(W'(i + 4), 4'd2, ADD, w);
      total += w;
    end
    in_valid = 1'b0;
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL throughput: stalled %0d cycles, required 0", total);
    end
    wait_results(4);
    check_res("b2b_0", 0, 4'd6, 1'b0, 1'b0);
    check_res("b2b_3", 3, 4'd9, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int idx, w;
    res_q.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; a = W'(idx + 1); b = W'(idx + 1); mode = ADD;
      #1;
      if (c >= 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: cycle %0d in_ready=%b, required 0", c, in_ready);
        end
      end
      if (in_ready) idx++;
      @(posedge clk); #1;
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== 4'd2 || carry !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d valid=%b sum=%0d, required 1 2", c, out_valid, sum);
        end
      end
    end
    checks++;
    if (idx != 2) begin
      errors++;
      $display("FAIL bp_accepted: %0d beats, required 2", idx);
    end
    out_ready = 1'b1;
    while (idx < 4) begin
      push_beat(W'(idx + 1), W'(idx + 1), ADD, w);
      idx++;
    end
    in_valid = 1'b0;
    wait_results(4);
    check_res("bp_r0", 0, 4'd2, 1'b0, 1'b0);
    check_res("bp_r1", 1, 4'd4, 1'b0, 1'b0);
    check_res("bp_r2", 2, 4'd6, 1'b0, 1'b0);
    check_res("bp_r3", 3, 4'd8, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: %0d results, required 4", res_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int w;
    res_q.delete();
    out_ready = 1'b0;
    push_beat(4'd7, 4'd0, LOAD, w);
    push_beat(4'd1, 4'd1, ADD,  w);
    in_valid = 1'b1; a = 4'd5; b = 4'd0; mode = ACC; out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drain: out_valid=%b, required 0", out_valid);
    end
    push_beat(4'd2, 4'd0, ACC, w);
    in_valid = 1'b0;
    wait_results(1);
    check_res("acc_after_rst", 0, 4'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res_q.size() != 1) begin
      errors++;
      $display("FAIL mid_reset_count: %0d results, required 1", res_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_add_sub();
    test_acc();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
